// File: rtl/instr_fetch_if.sv
// Instruction-memory read port of the fetch stage: the fetch unit drives the word address and
// the memory returns the instruction at that address in the same cycle.
interface instr_fetch_if #(
  parameter int unsigned ISIZE = 16
);
  logic [ISIZE-1:0] imem_addr;
  logic [ISIZE-1:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: PC sequencing, the IF/ID register, the EX/MEM forwarding history and a
// single-instruction EXEC detour that returns to the interrupted PC.
module instr_fetch #(
  parameter int unsigned      ISIZE = 16,
  parameter logic [ISIZE-1:0] NOP   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_if.master       imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ISIZE-1:0]    redirect_pc,
  input  logic                exec_req,
  input  logic [ISIZE-1:0]    exec_pc,
  output logic [ISIZE-1:0]    id_instr,
  output logic [ISIZE-1:0]    id_pc,
  output logic [ISIZE-1:0]    last_instr,
  output logic [ISIZE-1:0]    last2_instr,
  output logic                exec_busy
);

  typedef enum logic {StRun, StExecOne} state_e;

  state_e           state_q, state_d;
  logic [ISIZE-1:0] pc_q, pc_d;
  logic [ISIZE-1:0] ret_pc_q, ret_pc_d;
  logic [ISIZE-1:0] id_instr_q, id_instr_d;
  logic [ISIZE-1:0] id_pc_q, id_pc_d;
  logic [ISIZE-1:0] last_q, last_d;
  logic [ISIZE-1:0] last2_q, last2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      if (redirect) begin
        state_d = StRun;
      end else if (exec_req) begin
        state_d = StExecOne;
      end else begin
        state_d = StRun;
      end
    end
  end

  always_comb begin
    exec_busy = (state_q == StExecOne);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      ret_pc_q   <= '0;
      id_instr_q <= NOP;
      id_pc_q    <= '0;
      last_q     <= NOP;
      last2_q    <= NOP;
    end else begin
      pc_q       <= pc_d;
      ret_pc_q   <= ret_pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      last_q     <= last_d;
      last2_q    <= last2_d;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    ret_pc_d   = ret_pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    last2_d    = last_q;
    last_d     = NOP;
    if (!stall) begin
      last_d = id_instr_q;
      if (redirect) begin
        pc_d       = redirect_pc;
        id_instr_d = NOP;
        id_pc_d    = pc_q;
      end else if (exec_req) begin
        // A nested EXEC overwrites the return address with the current (EXEC target) PC.
        ret_pc_d   = pc_q;
        pc_d       = exec_pc;
        id_instr_d = NOP;
        id_pc_d    = pc_q;
      end else begin
        id_instr_d = imem.imem_data;
        id_pc_d    = pc_q;
        pc_d       = (state_q == StExecOne) ? ret_pc_q : pc_q + 1'b1;
      end
    end
  end

  assign imem.imem_addr = pc_q;
  assign id_instr       = id_instr_q;
  assign id_pc          = id_pc_q;
  assign last_instr     = last_q;
  assign last2_instr    = last2_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ISIZE, default 16, instruction and PC width.
REQ-002 SHALL have parameter NOP, default 16'h0000, bubble encoding (ADD R0,R0,R0).
REQ-003 SHALL have clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have imem_addr, output, ISIZE: word address to instruction memory; equals the pc register, combinational.
REQ-006 SHALL have imem_data, input, ISIZE: instruction at imem_addr, valid in the same cycle.
REQ-007 SHALL have stall, input, 1: hazard hold request from the decode/control side.
REQ-008 SHALL have redirect, input, 1: taken B, JAL or JR decoded in ID.
REQ-009 SHALL have redirect_pc, input, ISIZE: target for redirect.
REQ-010 SHALL have exec_req, input, 1: EXEC decoded in ID.
REQ-011 SHALL have exec_pc, input, ISIZE: address of the instruction EXEC runs.
REQ-012 SHALL have id_instr, output, ISIZE: IF/ID instruction register.
REQ-013 SHALL have id_pc, output, ISIZE: address of id_instr.
REQ-014 SHALL have last_instr, output, ISIZE: instruction now in EX, used for forwarding.
REQ-015 SHALL have last2_instr, output, ISIZE: instruction now in MEM, used for forwarding.
REQ-016 SHALL have exec_busy, output, 1: high while in state EXEC_ONE.

Function
REQ-017 SHALL implement states RUN and EXEC_ONE; pc, ret_pc, id_instr, id_pc, last_instr, last2_instr SHALL be registers.
REQ-018 The decision order each cycle SHALL be: stall, then redirect, then exec_req, then EXEC_ONE completion, then sequential fetch.
REQ-019 Sequential fetch (RUN, no event): pc <= pc+1, mod 2^ISIZE, wrapping FFFF->0000; id_instr <= imem_data; id_pc <= pc.
REQ-020 Every non-stall cycle SHALL shift history: last2_instr <= last_instr; last_instr <= id_instr.
REQ-021 stall=1: pc, id_instr, id_pc, state and ret_pc SHALL hold; last2_instr <= last_instr; last_instr <= NOP (bubble into EX).
REQ-022 redirect=1, no stall: pc <= redirect_pc; id_instr <= NOP; id_pc <= pc; ret_pc unchanged; state <= RUN, also if in EXEC_ONE.
REQ-023 exec_req=1, no stall, no redirect: ret_pc <= pc; pc <= exec_pc; id_instr <= NOP; state <= EXEC_ONE.
REQ-024 EXEC_ONE, no stall, no redirect, no exec_req: id_instr <= imem_data; id_pc <= pc; pc <= ret_pc; state <= RUN.
REQ-025 exec_req while in EXEC_ONE (nested EXEC) SHALL be handled as in REQ-023, overwriting ret_pc.
REQ-026 Latency: a redirect or exec target instruction SHALL appear on id_instr exactly 2 cycles after the request edge, provided there is no stall.
REQ-027 exec_busy SHALL equal (state == EXEC_ONE).
REQ-028 redirect and exec_req simultaneous: redirect SHALL win and exec_req SHALL be ignored.

Reset
REQ-029 While rst_n=0, regardless of clk: pc=0, ret_pc=0, id_instr=NOP, id_pc=0, last_instr=NOP, last2_instr=NOP, state=RUN, exec_busy=0.
REQ-030 Reset asserted mid-EXEC SHALL abandon ret_pc; after release, fetch SHALL restart at address 0.
REQ-031 The first fetch after rst_n rises SHALL place imem[0] in id_instr on the first clk edge.

Verification
REQ-032 Sequential run: memory with instr i = 16'h0100+i, no events, 4 edges after reset -> id_instr=0103, id_pc=3, last_instr=0102, last2_instr=0101, imem_addr=4.
REQ-033 Redirect: pc=5, redirect=1, redirect_pc=0x0040 for one cycle -> next edge id_instr=NOP, imem_addr=0x40; following edge id_instr=imem[0x40], id_pc=0x40.
REQ-034 EXEC: pc=8, exec_req=1, exec_pc=0x20 -> exec_busy=1 and imem_addr=0x20; next edge id_instr=imem[0x20], imem_addr=8, exec_busy=0; next edge id_instr=imem[8].
REQ-035 Stall: 2-cycle stall with id_instr=0x1234 -> id_instr and pc hold; last_instr=NOP for both cycles; last2_instr=NOP after the second cycle.
REQ-036 Priority and wrap: redirect and exec_req together -> pc=redirect_pc and exec_busy stays 0; pc=FFFF with no event -> imem_addr=0000 next cycle.
REQ-037 Reset mid-EXEC: rst_n low while exec_busy=1 -> all outputs at reset values immediately; after release fetch starts at address 0.
